// File: rtl/dmem_arbiter.sv
// Two-port valid/ready arbiter that sequences single-cycle accesses onto the shared datamemory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [DM_ADDRESS-1:0] p0_req_addr,
  input  logic [DATA_W-1:0]     p0_req_wdata,
  input  logic [2:0]            p0_req_funct3,
  output logic                  p0_rsp_valid,
  output logic [DATA_W-1:0]     p0_rsp_rdata,
  output logic                  p0_rsp_err,

  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [DM_ADDRESS-1:0] p1_req_addr,
  input  logic [DATA_W-1:0]     p1_req_wdata,
  input  logic [2:0]            p1_req_funct3,
  output logic                  p1_rsp_valid,
  output logic [DATA_W-1:0]     p1_rsp_rdata,
  output logic                  p1_rsp_err,

  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]            state;
  logic                  lat_we;
  logic [DM_ADDRESS-1:0] lat_addr;
  logic [DATA_W-1:0]     lat_wdata;
  logic [2:0]            lat_funct3;
  logic                  owner;
  logic [DATA_W-1:0]     rsp_data;
  logic                  rsp_error;

  logic                  sel;
  logic                  accept;
  logic                  sel_we;
  logic [DM_ADDRESS-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [2:0]            sel_funct3;
  logic                  funct3_ok;
  logic                  misaligned;
  logic                  sel_legal;
  logic                  in_access;
  logic                  in_resp;

`ifdef DMEM_ARB_RR_EN
  logic last_grant;

  // Contention goes to the port that did not win last time.
  always_comb begin
    sel = (p0_req_valid && p1_req_valid) ? ~last_grant : p1_req_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= sel;
    end
  end
`else
  always_comb begin
    sel = ~p0_req_valid & p1_req_valid;
  end
`endif

  // Ready is held low while reset is asserted so every output is quiet during reset.
  assign accept       = (state == S_IDLE) && rst_n && (p0_req_valid || p1_req_valid);
  assign p0_req_ready = accept & ~sel;
  assign p1_req_ready = accept & sel;

  assign sel_we     = sel ? p1_req_we     : p0_req_we;
  assign sel_addr   = sel ? p1_req_addr   : p0_req_addr;
  assign sel_wdata  = sel ? p1_req_wdata  : p0_req_wdata;
  assign sel_funct3 = sel ? p1_req_funct3 : p0_req_funct3;

  always_comb begin
    funct3_ok = 1'b0;
    case (sel_funct3)
      3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
      3'b100, 3'b101:         funct3_ok = ~sel_we;
      default:                funct3_ok = 1'b0;
    endcase
    misaligned = ((sel_funct3[1:0] == 2'b01) && sel_addr[0]) ||
                 ((sel_funct3[1:0] == 2'b10) && (sel_addr[1:0] != 2'b00));
    sel_legal  = funct3_ok & ~misaligned;
  end

  // Illegal requests skip ACCESS and report the error straight away with no memory strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= 3'b000;
      owner      <= 1'b0;
      rsp_data   <= '0;
      rsp_error  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_we     <= sel_we;
            lat_addr   <= sel_addr;
            lat_wdata  <= sel_wdata;
            lat_funct3 <= sel_funct3;
            owner      <= sel;
            rsp_data   <= '0;
            rsp_error  <= ~sel_legal;
            state      <= sel_legal ? S_ACCESS : S_RESP;
          end
        end
        S_ACCESS: begin
          rsp_data  <= lat_we ? '0 : mem_rdata;
          rsp_error <= 1'b0;
          state     <= S_RESP;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_access = (state == S_ACCESS);
  assign in_resp   = (state == S_RESP);

  assign mem_read   = in_access & ~lat_we;
  assign mem_write  = in_access & lat_we;
  assign mem_addr   = in_access ? lat_addr   : '0;
  assign mem_wdata  = in_access ? lat_wdata  : '0;
  assign mem_funct3 = in_access ? lat_funct3 : 3'b000;

  assign p0_rsp_valid = in_resp & ~owner;
  assign p0_rsp_rdata = (in_resp && !owner) ? rsp_data : '0;
  assign p0_rsp_err   = in_resp & ~owner & rsp_error;

  assign p1_rsp_valid = in_resp & owner;
  assign p1_rsp_rdata = (in_resp && owner) ? rsp_data : '0;
  assign p1_rsp_err   = in_resp & owner & rsp_error;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic scored
// against a transaction-level reference model and a byte-array memory model.
module tb_dmem_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    f3;
  } req_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req_valid = 1'b0, p1_req_valid = 1'b0;
  logic          p0_req_we = 1'b0, p1_req_we = 1'b0;
  logic [AW-1:0] p0_req_addr = '0, p1_req_addr = '0;
  logic [DW-1:0] p0_req_wdata = '0, p1_req_wdata = '0;
  logic [2:0]    p0_req_funct3 = '0, p1_req_funct3 = '0;
  logic          p0_req_ready, p1_req_ready;
  logic          p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err;
  logic [DW-1:0] p0_rsp_rdata, p1_rsp_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_funct3;
  logic [DW-1:0] mem_rdata;

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_funct3(p0_req_funct3),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_funct3(p1_req_funct3),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Stand-in for datamemory: synchronous write, combinational sized/sign-extended read.
  logic [7:0]  env_mem [0:511] = '{default: 8'h00};
  logic [31:0] env_word;

  always @(posedge clk) begin
    if (mem_write) begin
      env_mem[mem_addr] <= mem_wdata[7:0];
      if (mem_funct3[1:0] != 2'b00) env_mem[AW'(mem_addr + 1)] <= mem_wdata[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        env_mem[AW'(mem_addr + 2)] <= mem_wdata[23:16];
        env_mem[AW'(mem_addr + 3)] <= mem_wdata[31:24];
      end
    end
  end

  always_comb begin
    env_word  = {env_mem[AW'(mem_addr + 3)], env_mem[AW'(mem_addr + 2)],
                 env_mem[AW'(mem_addr + 1)], env_mem[mem_addr]};
    mem_rdata = 32'hBAD0_BAD0;
    if (mem_read) begin
      case (mem_funct3)
        3'b000:  mem_rdata = {{24{env_word[7]}}, env_word[7:0]};
        3'b001:  mem_rdata = {{16{env_word[15]}}, env_word[15:0]};
        3'b100:  mem_rdata = {24'h0, env_word[7:0]};
        3'b101:  mem_rdata = {16'h0, env_word[15:0]};
        default: mem_rdata = env_word;
      endcase
    end
  end

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  req_t q0[$], q1[$];
  int   grant_log[$];
  logic [DW-1:0] last0_data, last1_data;
  logic          last0_err, last1_err;
  int   strobe_cnt = 0;
  int   wr_cnt = 0;

  // Reference model state: when the arbiter is next free and what it owes.
  logic [7:0]    ref_mem [0:511] = '{default: 8'h00};
  int            free_cyc = 0;
  int            acc_cyc = -1;
  int            rsp_cyc = -1;
  req_t          acc_req;
  int            rsp_port = 0;
  logic [DW-1:0] rsp_data = '0;
  logic          rsp_err = 1'b0;
  int            last_grant = 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit isLegal(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr);
    int size;
    bit code_ok;
    size = 1 << f3[1:0];
    if (we) code_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    code_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return code_ok && ((int'(addr) % size) == 0);
  endfunction

  function automatic logic [31:0] refLoad(input logic [AW-1:0] addr, input logic [2:0] f3);
    int size;
    longint unsigned v;
    size = 1 << f3[1:0];
    v = 0;
    for (int i = 0; i < size; i++) v = v + (longint'(ref_mem[AW'(int'(addr) + i)]) << (8 * i));
    if (!f3[2] && size < 4 && (((v >> (8 * size - 1)) & 1) == 1)) v = v - (64'd1 << (8 * size));
    return v[31:0];
  endfunction

  task automatic refStore(input logic [AW-1:0] addr, input logic [2:0] f3, input logic [31:0] data);
    int size;
    size = 1 << f3[1:0];
    for (int i = 0; i < size; i++) ref_mem[AW'(int'(addr) + i)] = 8'(data >> (8 * i));
  endtask

  task automatic applyStimulus();
    if (q0.size() > 0) begin
      p0_req_valid = 1'b1; p0_req_we = q0[0].we; p0_req_addr = q0[0].addr;
      p0_req_wdata = q0[0].wdata; p0_req_funct3 = q0[0].f3;
    end else begin
      p0_req_valid = 1'b0;
    end
    if (q1.size() > 0) begin
      p1_req_valid = 1'b1; p1_req_we = q1[0].we; p1_req_addr = q1[0].addr;
      p1_req_wdata = q1[0].wdata; p1_req_funct3 = q1[0].f3;
    end else begin
      p1_req_valid = 1'b0;
    end
  endtask

  task automatic modelCycle();
    bit   idle, win, e_r0, e_r1, in_acc, e_v0, e_v1;
    req_t r;
    idle = (cyc >= free_cyc);
`ifdef DMEM_ARB_RR_EN
    win = (p0_req_valid && p1_req_valid) ? (last_grant == 0) : p1_req_valid;
`else
    win = !p0_req_valid;
`endif
    e_r0 = idle && p0_req_valid && !win;
    e_r1 = idle && p1_req_valid && win;
    checkOutput("p0_ready", p0_req_ready, e_r0);
    checkOutput("p1_ready", p1_req_ready, e_r1);

    in_acc = (cyc == acc_cyc);
    checkOutput("mem_read",   mem_read,   in_acc && !acc_req.we);
    checkOutput("mem_write",  mem_write,  in_acc && acc_req.we);
    checkOutput("mem_addr",   mem_addr,   in_acc ? acc_req.addr : 0);
    checkOutput("mem_wdata",  mem_wdata,  in_acc ? acc_req.wdata : 0);
    checkOutput("mem_funct3", mem_funct3, in_acc ? acc_req.f3 : 0);
    if (in_acc) begin
      if (acc_req.we) refStore(acc_req.addr, acc_req.f3, acc_req.wdata);
      else rsp_data = refLoad(acc_req.addr, acc_req.f3);
    end

    e_v0 = (cyc == rsp_cyc) && (rsp_port == 0);
    e_v1 = (cyc == rsp_cyc) && (rsp_port == 1);
    checkOutput("p0_rsp_valid", p0_rsp_valid, e_v0);
    checkOutput("p1_rsp_valid", p1_rsp_valid, e_v1);
    checkOutput("p0_rsp_rdata", p0_rsp_rdata, e_v0 ? rsp_data : 0);
    checkOutput("p1_rsp_rdata", p1_rsp_rdata, e_v1 ? rsp_data : 0);
    checkOutput("p0_rsp_err",   p0_rsp_err,   e_v0 && rsp_err);
    checkOutput("p1_rsp_err",   p1_rsp_err,   e_v1 && rsp_err);

    if (e_r0 || e_r1) begin
      r = '{we: win ? p1_req_we : p0_req_we, addr: win ? p1_req_addr : p0_req_addr,
            wdata: win ? p1_req_wdata : p0_req_wdata, f3: win ? p1_req_funct3 : p0_req_funct3};
      last_grant = int'(win);
      rsp_port = int'(win);
      rsp_data = '0;
      if (isLegal(r.we, r.f3, r.addr)) begin
        acc_req = r; acc_cyc = cyc + 1; rsp_cyc = cyc + 2; free_cyc = cyc + 3; rsp_err = 1'b0;
      end else begin
        rsp_cyc = cyc + 1; free_cyc = cyc + 2; rsp_err = 1'b1;
      end
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    applyStimulus();
    @(negedge clk);
    modelCycle();
    if (p0_rsp_valid) begin last0_data = p0_rsp_rdata; last0_err = p0_rsp_err; end
    if (p1_rsp_valid) begin last1_data = p1_rsp_rdata; last1_err = p1_rsp_err; end
    if (mem_read || mem_write) strobe_cnt++;
    if (mem_write) wr_cnt++;
    if (p0_req_ready) begin grant_log.push_back(0); if (q0.size() > 0) q0.delete(0); end
    if (p1_req_ready) begin grant_log.push_back(1); if (q1.size() > 0) q1.delete(0); end
    cyc++;
  endtask

  task automatic drain();
    int budget;
    budget = 300;
    while ((q0.size() != 0 || q1.size() != 0 || cyc < free_cyc) && budget > 0) begin
      stepCycle();
      budget--;
    end
    if (budget == 0) begin
      checkOutput("drain_timeout", 1, 0);
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic clearObs();
    last0_data = 32'h5A5A_5A5A; last1_data = 32'h5A5A_5A5A;
    last0_err = 1'b0; last1_err = 1'b0;
    strobe_cnt = 0; wr_cnt = 0;
    grant_log.delete();
  endtask

  task automatic checkAllQuiet(input string tag);
    checkOutput(tag, {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err,
                      p1_rsp_err, mem_read, mem_write, mem_funct3}, 0);
    checkOutput({tag, "_data"}, {p0_rsp_rdata, p1_rsp_rdata}, 0);
    checkOutput({tag, "_mem"}, {mem_addr, mem_wdata}, 0);
  endtask

  function automatic req_t mkReq(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                                 input logic [31:0] wdata);
    req_t r;
    r.we = we; r.f3 = f3; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic req_t randReq();
    req_t r;
    int   k, size;
    r.we = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 9) < 8) begin
      k = $urandom_range(0, 4);
      r.f3 = (k < 3) ? 3'(k) : 3'(k + 1);
    end else begin
      r.f3 = 3'($urandom_range(0, 7));
    end
    r.addr = AW'($urandom_range(0, 63));
    size = 1 << r.f3[1:0];
    if ($urandom_range(0, 9) < 7) r.addr = AW'((int'(r.addr) / size) * size);
    r.wdata = $urandom;
    return r;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    checkAllQuiet("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Store then load on port 0.
    clearObs();
    q0.push_back(mkReq(1'b1, 3'b010, 9'h010, 32'hDEAD_BEEF));
    q0.push_back(mkReq(1'b0, 3'b010, 9'h010, 32'h0));
    drain();
    checkOutput("sw_lw_data", last0_data, 32'hDEAD_BEEF);
    checkOutput("sw_lw_err", last0_err, 0);
    checkOutput("sw_write_cycles", wr_cnt, 1);

    // Misaligned halfword on port 1.
    clearObs();
    q1.push_back(mkReq(1'b0, 3'b001, 9'h013, 32'h0));
    drain();
    checkOutput("lh_mis_err", last1_err, 1);
    checkOutput("lh_mis_data", last1_data, 0);
    checkOutput("lh_mis_strobes", strobe_cnt, 0);

    // Both ports contending continuously.
    clearObs();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mkReq(1'b0, 3'b010, AW'(4 * i), 32'h0));
      q1.push_back(mkReq(1'b0, 3'b010, AW'(32 + 4 * i), 32'h0));
    end
    drain();
    checkOutput("contend_grants", grant_log.size(), 8);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      checkOutput($sformatf("rr_grant%0d", i), grant_log.size() > i ? grant_log[i] : -1, i % 2);
`else
      checkOutput($sformatf("fixed_grant%0d", i), grant_log.size() > i ? grant_log[i] : -1, 0);
`endif
    end

    // Signed and unsigned byte loads.
    clearObs();
    q0.push_back(mkReq(1'b1, 3'b010, 9'h010, 32'h0000_80FF));
    q0.push_back(mkReq(1'b0, 3'b000, 9'h011, 32'h0));
    drain();
    checkOutput("lb_sign", last0_data, 32'hFFFF_FF80);
    q0.push_back(mkReq(1'b0, 3'b100, 9'h011, 32'h0));
    drain();
    checkOutput("lbu_zero", last0_data, 32'h0000_0080);

    // Reset while a store is in ACCESS; the store must be dropped.
    clearObs();
    q0.push_back(mkReq(1'b1, 3'b010, 9'h030, 32'h1234_5678));
    stepCycle();
    @(posedge clk);
    #1;
    applyStimulus();
    #1;
    checkOutput("rst_pre_write", mem_write, 1);
    rst_n = 1'b0;
    #1;
    checkAllQuiet("rst_mid_access");
    @(negedge clk);
    cyc++;
    repeat (2) begin
      @(negedge clk);
      checkAllQuiet("rst_held");
      cyc++;
    end
    rst_n = 1'b1;
    acc_cyc = -1; rsp_cyc = -1; free_cyc = cyc; last_grant = 1;
    grant_log.delete();
    q1.push_back(mkReq(1'b0, 3'b010, 9'h010, 32'h0));
    q0.push_back(mkReq(1'b0, 3'b010, 9'h030, 32'h0));
    drain();
    checkOutput("post_rst_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    checkOutput("dropped_store", last0_data, 0);

    // Unsupported size code on an aligned address.
    clearObs();
    q0.push_back(mkReq(1'b0, 3'b011, 9'h020, 32'h0));
    drain();
    checkOutput("f3_011_err", last0_err, 1);
    checkOutput("f3_011_data", last0_data, 0);
    checkOutput("f3_011_strobes", strobe_cnt, 0);

    // Random traffic on both ports.
    for (int n = 0; n < 500; n++) begin
      if (q0.size() == 0 && $urandom_range(0, 2) != 0) q0.push_back(randReq());
      if (q1.size() == 0 && $urandom_range(0, 2) != 0) q1.push_back(randReq());
      stepCycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
